// File: rtl/md_cart_if.sv
// Cartridge bus and memory port bundle for md_cart.
// slave = the cart bridge view, master = the 68k bus / memory controller view.
interface md_cart_if;
   logic [22:0] cart_address;
   logic        cart_cs;
   logic        cart_oe;
   logic        cart_lwr;
   logic        cart_uwr;
   logic        cart_time;
   logic [15:0] cart_data_wr;
   logic [15:0] cart_data;
   logic        cart_data_en;
   logic        ext_dtack;
   logic        mem_req;
   logic        mem_we;
   logic        mem_sram;
   logic [1:0]  mem_be;
   logic [23:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_ack;

   modport slave (
      input  cart_address, cart_cs, cart_oe, cart_lwr, cart_uwr, cart_time, cart_data_wr,
      input  mem_rdata, mem_ack,
      output cart_data, cart_data_en, ext_dtack,
      output mem_req, mem_we, mem_sram, mem_be, mem_addr, mem_wdata
   );

   modport master (
      output cart_address, cart_cs, cart_oe, cart_lwr, cart_uwr, cart_time, cart_data_wr,
      output mem_rdata, mem_ack,
      input  cart_data, cart_data_en, ext_dtack,
      input  mem_req, mem_we, mem_sram, mem_be, mem_addr, mem_wdata
   );
endinterface

// File: rtl/md_cart.sv
// Mega Drive cartridge bus bridge onto a single ROM/save-RAM memory port.
// Define MD_CART_SSF2_EN to enable the SSF2 bank mapper at $A130F3-$A130FF.
module md_cart #(
   parameter int ROM_WORDS_LOG2 = 21
) (
   input  logic     MCLK2,
   input  logic     ext_reset,
   md_cart_if.slave bus
);
   typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

   state_t      state_reg;
   logic        strobe;
   logic        strobe_reg;
   logic        start;
   logic        is_write;
   logic        sram_sel;
   logic        ignore_wr;
   logic        regs_wr;
   logic [23:0] rom_addr;
   logic [23:0] sel_addr;
   logic        sram_en_reg;
   logic        wp_reg;
   logic        dtack_reg;
   logic        rd_reg;
   logic        mem_req_reg;
   logic        mem_we_reg;
   logic        mem_sram_reg;
   logic [1:0]  mem_be_reg;
   logic [23:0] mem_addr_reg;
   logic [15:0] mem_wdata_reg;
   logic [15:0] data_reg;

   assign strobe    = bus.cart_cs & (bus.cart_oe | bus.cart_lwr | bus.cart_uwr);
   assign start     = strobe & ~strobe_reg & ~bus.cart_time;
   assign is_write  = bus.cart_lwr | bus.cart_uwr;
   assign sram_sel  = sram_en_reg & bus.cart_address[20];
   assign ignore_wr = is_write & (~sram_sel | wp_reg);
   assign regs_wr   = bus.cart_time & bus.cart_lwr;

`ifdef MD_CART_SSF2_EN
   logic [5:0] bank_w [8];
   genvar gi;

   assign bank_w[0] = 6'd0;
   generate
      for (gi = 1; gi < 8; gi++) begin : g_bank
         logic [5:0] bank_reg;
         always_ff @(posedge MCLK2 or posedge ext_reset) begin
            if (ext_reset) begin
               bank_reg <= 6'(gi);
            end else if (regs_wr && bus.cart_address[6:3] == 4'hF
                         && bus.cart_address[2:0] == 3'(gi)) begin
               bank_reg <= bus.cart_data_wr[5:0];
            end
         end
         assign bank_w[gi] = bank_reg;
      end
   endgenerate

   assign rom_addr = {bank_w[bus.cart_address[20:18]], bus.cart_address[17:0]};
`else
   localparam logic [23:0] ROM_MASK = 24'((25'd1 << ROM_WORDS_LOG2) - 25'd1);

   assign rom_addr = {1'b0, bus.cart_address} & ROM_MASK;
`endif

   // Save RAM is a 32K-word window mirrored across $200000-$3FFFFF.
   assign sel_addr = sram_sel ? {9'h0, bus.cart_address[14:0]} : rom_addr;

   always_ff @(posedge MCLK2 or posedge ext_reset) begin
      if (ext_reset) begin
         state_reg     <= IDLE;
         strobe_reg    <= 1'b0;
         sram_en_reg   <= 1'b0;
         wp_reg        <= 1'b0;
         dtack_reg     <= 1'b0;
         rd_reg        <= 1'b0;
         mem_req_reg   <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_sram_reg  <= 1'b0;
         mem_be_reg    <= 2'b00;
         mem_addr_reg  <= 24'h0;
         mem_wdata_reg <= 16'h0;
         data_reg      <= 16'h0;
      end else begin
         strobe_reg <= strobe;
         if (regs_wr && bus.cart_address[6:0] == 7'h78) begin
            sram_en_reg <= bus.cart_data_wr[0];
            wp_reg      <= bus.cart_data_wr[1];
         end
         case (state_reg)
            IDLE: begin
               if (start) begin
                  mem_we_reg    <= is_write;
                  mem_sram_reg  <= sram_sel;
                  mem_be_reg    <= is_write ? {bus.cart_uwr, bus.cart_lwr} : 2'b11;
                  mem_addr_reg  <= sel_addr;
                  mem_wdata_reg <= bus.cart_data_wr;
                  rd_reg        <= ~is_write;
                  if (ignore_wr) begin
                     state_reg <= HOLD;
                     dtack_reg <= 1'b1;
                  end else begin
                     state_reg   <= REQ;
                     mem_req_reg <= 1'b1;
                  end
               end
            end
            REQ: begin
               if (bus.mem_ack) begin
                  mem_req_reg <= 1'b0;
                  if (!mem_we_reg) begin
                     data_reg <= bus.mem_rdata;
                  end
                  dtack_reg <= 1'b1;
                  state_reg <= HOLD;
               end
            end
            HOLD: begin
               if (!strobe) begin
                  dtack_reg <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: begin
               state_reg   <= IDLE;
               dtack_reg   <= 1'b0;
               mem_req_reg <= 1'b0;
            end
         endcase
      end
   end

   // Gating with the live strobe lets DTACK release in the cycle the 68k ends the access.
   assign bus.ext_dtack    = dtack_reg & strobe;
   assign bus.cart_data_en = dtack_reg & rd_reg & strobe;
   assign bus.cart_data    = data_reg;
   assign bus.mem_req      = mem_req_reg;
   assign bus.mem_we       = mem_we_reg;
   assign bus.mem_sram     = mem_sram_reg;
   assign bus.mem_be       = mem_be_reg;
   assign bus.mem_addr     = mem_addr_reg;
   assign bus.mem_wdata    = mem_wdata_reg;
endmodule

// File: doc/md_cart.md
MD_CART -- requirements
Module: md_cart

Interface
REQ-001 SHALL have parameter ROM_WORDS_LOG2, default 21: number of ROM word-address bits decoded without the mapper.
REQ-002 SHALL have port MCLK2, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port ext_reset, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have these bus-side inputs, all strobes active-high:
- cart_address, 23 bits: 68k word address A23..A1.
- cart_cs, 1 bit: cart space select.
- cart_oe, 1 bit: read strobe.
- cart_lwr, 1 bit: low-byte write strobe.
- cart_uwr, 1 bit: high-byte write strobe.
- cart_time, 1 bit: $A130xx register-window select.
- cart_data_wr, 16 bits: write data.
REQ-005 SHALL have these bus-side outputs:
- cart_data, 16 bits: read data.
- cart_data_en, 1 bit: read-data drive enable.
- ext_dtack, 1 bit: 1 = pull DTACK low.
REQ-006 SHALL have these memory-side outputs:
- mem_req, 1 bit: request, level.
- mem_we, 1 bit: write.
- mem_sram, 1 bit: target is save RAM, not ROM.
- mem_be, 2 bits: byte enables {upper, lower}.
- mem_addr, 24 bits: word address.
- mem_wdata, 16 bits: write data.
REQ-007 SHALL have these memory-side inputs:
- mem_rdata, 16 bits: read data.
- mem_ack, 1 bit: single-cycle completion pulse.

Function
REQ-008 SHALL start an access in the cycle after a rising edge of cart_cs & (cart_oe | cart_lwr | cart_uwr).
REQ-009 SHALL never start an access while cart_time=1.
REQ-010 SHALL implement FSM states IDLE, REQ, HOLD.
REQ-011 IDLE -> REQ on a start that needs memory.
REQ-012 IDLE -> HOLD directly on an ignored write:
- any write to ROM;
- a write to SRAM while write-protect=1.
REQ-013 In REQ, mem_req, mem_we, mem_sram, mem_be, mem_addr and mem_wdata SHALL stay stable until the mem_ack cycle.
REQ-014 In the mem_ack cycle the FSM SHALL capture mem_rdata for reads, deassert mem_req, and enter HOLD.
REQ-015 In HOLD:
- ext_dtack=1;
- for reads only, cart_data_en=1 and cart_data = the captured word.
REQ-016 HOLD -> IDLE on the first cycle with cart_cs=0 or all of cart_oe, cart_lwr, cart_uwr at 0; ext_dtack and cart_data_en SHALL drop in that same cycle.
REQ-017 A strobe still high when the FSM returns to IDLE SHALL NOT start a new access; only a fresh rising edge does.
REQ-018 Fixed read latency SHALL be: strobe edge -> mem_req at +1 cycle; mem_ack at cycle N -> ext_dtack/cart_data_en at N+1.
REQ-019 mem_be SHALL be {cart_uwr, cart_lwr} for writes and 2'b11 for reads.
REQ-020 mem_wdata SHALL be cart_data_wr.
REQ-021 A cart_time write with cart_lwr=1 and cart_address[6:0]=7'h78 ($A130F1) SHALL set sram_en = cart_data_wr[0] and write-protect = cart_data_wr[1].
REQ-022 SHALL NOT assert ext_dtack for cart_time accesses; the system chip acknowledges them.
REQ-023 SRAM select = sram_en & cart_address[20] (byte $200000-$3FFFFF).
REQ-024 For SRAM accesses, mem_sram=1 and mem_addr = {9'h0, cart_address[14:0]}.
REQ-025 For ROM accesses, mem_sram=0 and mem_addr is zero-extended from the ROM map (REQ-030/REQ-031).
REQ-026 A mem_ack while not in REQ SHALL be ignored.
REQ-027 A strobe edge while in REQ or HOLD SHALL be ignored.

Reset
REQ-028 While ext_reset=1:
- FSM = IDLE;
- mem_req, mem_we, mem_sram, cart_data_en, ext_dtack = 0;
- cart_data, mem_addr, mem_wdata = 0; mem_be = 0;
- sram_en = 0, write-protect = 0;
- bank[i] = i for i = 0..7;
- strobe edge detector state = 0.
REQ-029 Reset asserted mid-access SHALL abort it immediately, with mem_req=0 and ext_dtack=0 asynchronously; the memory side SHALL tolerate the dropped request.

Configuration
REQ-030 Macro MD_CART_SSF2_EN defined:
- eight 6-bit bank registers;
- a cart_time write with cart_lwr=1 and cart_address[6:0] = 7'h79..7'h7F ($A130F3..$A130FF) loads bank[1..7] = cart_data_wr[5:0];
- bank[0] is fixed at 0;
- ROM mem_addr = {bank[cart_address[20:18]], cart_address[17:0]}.
REQ-031 Macro MD_CART_SSF2_EN undefined:
- no bank registers;
- writes to $A130F3-$A130FF are ignored;
- ROM mem_addr = cart_address[ROM_WORDS_LOG2-1:0], zero-extended to 24 bits.

Verification
REQ-032 ROM read at cart_address=23'h000100, mem_ack 3 cycles after mem_req, mem_rdata=16'h4E71:
- mem_addr=24'h000100, mem_we=0, mem_be=2'b11;
- cart_data=16'h4E71, cart_data_en=1 and ext_dtack=1 one cycle after mem_ack;
- all drop in the cycle cart_oe falls.
REQ-033 ROM write (cart_lwr, data 16'hFFFF) -> no mem_req; ext_dtack=1 one cycle after the edge and held until cart_lwr=0.
REQ-034 SRAM enable and write at byte address $200002:
- $A130F1 write with 16'h0001 sets sram_en;
- write to cart_address=23'h100001 with cart_uwr=1 only, data 16'hAB00 -> mem_sram=1, mem_addr=24'h000001, mem_be=2'b10, mem_we=1;
- then $A130F1 write with 16'h0003 -> the same write gives no mem_req, ext_dtack still asserted.
REQ-035 With MD_CART_SSF2_EN defined:
- $A130FF write with 16'h0012, then read at cart_address=23'h1C0004 -> mem_addr=24'h480004;
- with the macro undefined, the same read -> mem_addr=24'h1C0004.
REQ-036 Reset mid-access: ext_reset=1 asserted in REQ -> mem_req=0 and ext_dtack=0 without waiting for a clock edge; a later mem_ack has no effect; after release, bank[5]=5 and sram_en=0.
